// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detectors and their bit serializer front end.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  // Bit-index width for a word; never below 1 so the counter always exists.
  function automatic int SER_CNT_W(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one framed bit per clock out.
// A holding register lets consecutive words stream with no idle bit between them.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic             ser_eof,
  output logic             busy
);

  localparam int CNT_W = SER_CNT_W(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_next;
  logic [WIDTH-1:0] sr, sr_next, sr_shifted;
  logic [WIDTH-1:0] hr, hr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             hr_full, hr_full_next;
  logic             accept;
  logic             last_bit;
  logic             out_bit;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("seq_bit_serializer: WIDTH must be in 2..32");
    end

    // Shift direction is fixed at elaboration so the output tap is a plain wire.
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
      assign out_bit    = sr[WIDTH-1];
    end else begin : g_lsb_first
      assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
      assign out_bit    = sr[0];
    end
  endgenerate

  assign in_ready  = !hr_full && !flush;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == LAST_IDX);

  assign ser_valid = (state == SER_SHIFT);
  assign ser_bit   = ser_valid ? out_bit : IDLE_BIT;
  assign ser_sof   = ser_valid && (cnt == '0);
  assign ser_eof   = ser_valid && last_bit;
  assign busy      = ser_valid || hr_full;

  always_comb begin
    state_next   = state;
    sr_next      = sr;
    cnt_next     = cnt;
    hr_next      = hr;
    hr_full_next = hr_full;

    if (flush) begin
      state_next   = SER_IDLE;
      hr_full_next = 1'b0;
      cnt_next     = '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (accept) begin
            sr_next    = in_data;
            cnt_next   = '0;
            state_next = SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (!last_bit) begin
            sr_next  = sr_shifted;
            cnt_next = cnt + CNT_W'(1);
            if (accept) begin
              hr_next      = in_data;
              hr_full_next = 1'b1;
            end
          // On the last bit the held word takes priority over a bypass from the input.
          end else if (hr_full) begin
            sr_next  = hr;
            cnt_next = '0;
            if (accept) begin
              hr_next = in_data;
            end else begin
              hr_full_next = 1'b0;
            end
          end else if (accept) begin
            sr_next  = in_data;
            cnt_next = '0;
          end else begin
            state_next = SER_IDLE;
            cnt_next   = '0;
          end
        end
        default: state_next = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SER_IDLE;
      sr      <= '0;
      cnt     <= '0;
      hr      <= '0;
      hr_full <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      cnt     <= cnt_next;
      hr      <= hr_next;
      hr_full <= hr_full_next;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed framing scenarios plus randomized
// streaming against a queue-based model of words in flight.
module tb_seq_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         in_ready, ser_bit, ser_valid, ser_sof, ser_eof, busy;

  logic [W-1:0] l_in_data = '0;
  logic         l_in_valid = 1'b0;
  logic         l_flush = 1'b0;
  logic         l_in_ready, l_ser_bit, l_ser_valid, l_ser_sof, l_ser_eof, l_busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Model: queue of words not yet fully sent; head is on the wire at bit position mpos.
  logic [W-1:0] mq[$];
  int           mpos = 0;
  bit           m_acc = 1'b0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_sof(ser_sof),
    .ser_eof(ser_eof), .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .flush(l_flush), .ser_bit(l_ser_bit), .ser_valid(l_ser_valid), .ser_sof(l_ser_sof),
    .ser_eof(l_ser_eof), .busy(l_busy)
  );

  function automatic logic [5:0] dut_out();
    return {in_ready, busy, ser_valid, ser_sof, ser_eof, ser_bit};
  endfunction

  function automatic logic [5:0] model_out();
    logic [W-1:0] w;
    logic         v;
    v = (mq.size() > 0);
    w = v ? mq[0] : '0;
    return {(mq.size() < 2) && !flush, v, v, v && (mpos == 0), v && (mpos == W - 1),
            v ? w[W-1-mpos] : 1'b0};
  endfunction

  task automatic model_edge();
    if (!rst_n || flush) begin
      mq.delete();
      mpos  = 0;
      m_acc = 1'b0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0) begin
        mpos++;
        if (mpos == W) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (m_acc) mq.push_back(in_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (dut_out() !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL reset_main: got %b want %b", dut_out(), 6'b100000);
    end
    tests_run++;
    if ({l_in_ready, l_busy, l_ser_valid, l_ser_sof, l_ser_eof, l_ser_bit} !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL reset_lsb: got %b want %b",
               {l_in_ready, l_busy, l_ser_valid, l_ser_sof, l_ser_eof, l_ser_bit}, 6'b100000);
    end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    tests_run++;
    if (dut_out() !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got %b want %b", dut_out(), 6'b100000);
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] exp_bits;
    logic [5:0]   exp;
    exp_bits = 8'b1011_0000;
    in_valid = 1'b1;
    in_data  = 8'hB0;
    #1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < W; k++) begin
      #1;
      exp = {1'b1, 1'b1, 1'b1, k == 0, k == W - 1, exp_bits[W-1-k]};
      tests_run++;
      if (dut_out() !== exp) begin
        tests_failed++;
        $display("[TB] FAIL single_bit%0d: got %b want %b", k, dut_out(), exp);
      end
      tick();
    end
    #1;
    tests_run++;
    if (dut_out() !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL single_end: got %b want %b", dut_out(), 6'b100000);
    end
  endtask

  task automatic test_stream(input string name, input logic [W-1:0] words[$], input int cycles);
    logic [31:0] got, want;
    int          idx, nbits;
    got = '0;
    want = '0;
    idx = 0;
    nbits = 0;
    foreach (words[i]) want = (want << W) | 32'(words[i]);
    for (int c = 0; c < cycles; c++) begin
      in_valid = (idx < words.size());
      in_data  = (idx < words.size()) ? words[idx] : '0;
      #1;
      tests_run++;
      if (dut_out() !== model_out()) begin
        tests_failed++;
        $display("[TB] FAIL %s_cycle%0d: got %b want %b", name, c, dut_out(), model_out());
      end
      if (ser_valid === 1'b1) begin
        got = {got[30:0], ser_bit};
        nbits++;
      end
      tick();
      if (m_acc) idx++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    tests_run++;
    if (got !== want || nbits != W * words.size()) begin
      tests_failed++;
      $display("[TB] FAIL %s_stream: got %h (%0d bits) want %h (%0d bits)", name, got, nbits,
               want, W * words.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[$];
    words = '{8'hA5, 8'h3C};
    test_stream("b2b", words, 19);
  endtask

  task automatic test_refill();
    logic [W-1:0] words[$];
    words = '{8'hFF, 8'h00, 8'h0B};
    test_stream("refill", words, 27);
  endtask

  task automatic test_flush();
    logic seen;
    in_valid = 1'b1;
    in_data  = 8'hB0;
    tick();
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    tests_run++;
    if ({in_ready, busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_hr_full: got %b want %b", {in_ready, busy}, 2'b01);
    end
    tick();
    flush = 1'b1;
    #1;
    tests_run++;
    if (dut_out() !== 6'b011001) begin
      tests_failed++;
      $display("[TB] FAIL flush_cycle: got %b want %b", dut_out(), 6'b011001);
    end
    tick();
    flush = 1'b0;
    #1;
    tests_run++;
    if (dut_out() !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL flush_after: got %b want %b", dut_out(), 6'b100000);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen |= (ser_valid !== 1'b0);
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_held_word: got valid=%b want valid=0", seen);
    end
  endtask

  task automatic test_reset_midword();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    mq.delete();
    mpos = 0;
    #1;
    tests_run++;
    if (dut_out() !== 6'b100000) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got %b want %b", dut_out(), 6'b100000);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    tests_run++;
    if (dut_out() !== 6'b111100) begin
      tests_failed++;
      $display("[TB] FAIL reset_new_sof: got %b want %b", dut_out(), 6'b111100);
    end
    repeat (9) tick();
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] exp_bits;
    logic [3:0]   exp;
    exp_bits = 8'b1011_0000;
    l_in_valid = 1'b1;
    l_in_data  = 8'h0D;
    tick();
    l_in_valid = 1'b0;
    l_in_data  = '0;
    for (int k = 0; k < W; k++) begin
      #1;
      exp = {1'b1, k == 0, k == W - 1, exp_bits[W-1-k]};
      tests_run++;
      if ({l_ser_valid, l_ser_sof, l_ser_eof, l_ser_bit} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL lsb_bit%0d: got %b want %b", k,
                 {l_ser_valid, l_ser_sof, l_ser_eof, l_ser_bit}, exp);
      end
      tick();
    end
    #1;
    tests_run++;
    if (l_ser_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lsb_end: got %b want %b", l_ser_valid, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
      flush = ($urandom_range(0, 24) == 0);
      #1;
      tests_run++;
      if (dut_out() !== model_out()) begin
        tests_failed++;
        $display("[TB] FAIL random_cycle%0d: got %b want %b", c, dut_out(), model_out());
      end
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2 * W + 2) tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_refill();
    test_flush();
    test_reset_midword();
    test_lsb_first();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
